// File: rtl/pe_flit_injector_if.sv
// Bundle of the PE-side and router-side signals of the flit injector.
// master: the environment (PE, router credit return, status observer).
// slave : the injector itself.
interface pe_flit_injector_if #(
  parameter int DEPTH = 4
) ();
  logic [70:0]            pe_flit;
  logic                   pe_ready_send;
  logic [70:0]            router_flit;
  logic [1:0]             credit_in;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   credit_err;

  modport master (
    output pe_flit, pe_ready_send, credit_in,
    input  router_flit, fifo_count, overflow, credit_err
  );

  modport slave (
    input  pe_flit, pe_ready_send, credit_in,
    output router_flit, fifo_count, overflow, credit_err
  );
endinterface

// File: rtl/pe_flit_injector.sv
// PE flit injector: buffers valid flits from the PE in an in-order FIFO and
// injects them into the local router port under per-VC credit flow control.
// The head flit leaves only when its own VC has credit; flits behind it wait
// (strict FIFO, head-of-line blocking is intentional).
module pe_flit_injector #(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_flit_injector_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(CREDITS) + 1;

  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO   = {(AW + 1){1'b0}};
  localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CREDITS_C  = CW'(CREDITS);
  localparam logic [CW-1:0] CRD_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CRD_ONE    = {{(CW - 1){1'b0}}, 1'b1};

  logic [70:0]   mem_q [DEPTH];
  logic [70:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] credit_q [2];
  logic [CW-1:0] credit_d [2];
  logic [70:0]   router_flit_q, router_flit_d;
  logic          overflow_q, overflow_d;
  logic          credit_err_q, credit_err_d;

  logic [70:0]   head_s;
  logic          head_vc_s;
  logic          push_req_s;
  logic          push_s;
  logic          pop_s;
  logic [1:0]    dec_s;

  // Decide pop (head has credit on its VC) and push (room now, or room freed by the pop).
  always_comb begin
    head_s     = mem_q[rd_ptr_q];
    head_vc_s  = head_s[64];
    pop_s      = (count_q != CNT_ZERO) && (credit_q[head_vc_s] != CRD_ZERO);
    push_req_s = bus.pe_ready_send && bus.pe_flit[70];
    push_s     = push_req_s && ((count_q < DEPTH_C) || pop_s);
    if (pop_s) begin
      dec_s = head_vc_s ? 2'b10 : 2'b01;
    end else begin
      dec_s = 2'b00;
    end
  end

  // Next state for FIFO storage, pointers, occupancy, output register and flags.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_s) begin
      mem_d[wr_ptr_q] = bus.pe_flit;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d      = rd_ptr_q + PTR_ONE;
      router_flit_d = head_s;
    end else begin
      rd_ptr_d      = rd_ptr_q;
      router_flit_d = 71'd0;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (push_req_s && !push_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    // A return and a pop on the same VC cancel; a return into a full counter is lost.
    credit_err_d = credit_err_q;
    for (int v = 0; v < 2; v++) begin
      case ({bus.credit_in[v], dec_s[v]})
        2'b01:   credit_d[v] = credit_q[v] - CRD_ONE;
        2'b10: begin
          if (credit_q[v] == CREDITS_C) begin
            credit_d[v]  = credit_q[v];
            credit_err_d = 1'b1;
          end else begin
            credit_d[v]  = credit_q[v] + CRD_ONE;
          end
        end
        default: credit_d[v] = credit_q[v];
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control state, credits and registered outputs with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= PTR_ZERO;
      rd_ptr_q      <= PTR_ZERO;
      count_q       <= CNT_ZERO;
      credit_q[0]   <= CREDITS_C;
      credit_q[1]   <= CREDITS_C;
      router_flit_q <= 71'd0;
      overflow_q    <= 1'b0;
      credit_err_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      credit_q[0]   <= credit_d[0];
      credit_q[1]   <= credit_d[1];
      router_flit_q <= router_flit_d;
      overflow_q    <= overflow_d;
      credit_err_q  <= credit_err_d;
    end
  end

  assign bus.router_flit = router_flit_q;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.credit_err  = credit_err_q;

endmodule

// File: tb/tb_pe_flit_injector.sv
// Table-driven bench for pe_flit_injector with an in-order scoreboard of
// expected injected flits.
module tb_pe_flit_injector;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pe_flit_injector_if #(.DEPTH(4)) bus ();

  pe_flit_injector #(.DEPTH(4), .CREDITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        rdy;
    logic [70:0] flit;
    logic [1:0]  cin;
    logic        acc;   // flit expected to be accepted into the FIFO
    logic [2:0]  cnt;   // expected fifo_count after the edge
    logic        emit;  // expected router_flit non-zero after the edge
    logic        ovf;
    logic        cerr;
  } vec_t;

  localparam logic [70:0] NF = 71'd0;

  vec_t        tbl [$];
  logic [70:0] exp_q [$];
  int          n_chk = 0;
  int          n_err = 0;

  function automatic vec_t V(logic rdy, logic [70:0] flit, logic [1:0] cin, logic acc,
                             logic [2:0] cnt, logic emit, logic ovf, logic cerr);
    vec_t v;
    v.rdy = rdy; v.flit = flit; v.cin = cin; v.acc = acc;
    v.cnt = cnt; v.emit = emit; v.ovf = ovf; v.cerr = cerr;
    return v;
  endfunction

  function automatic logic [70:0] mk(logic vc, logic [7:0] tag);
    return {1'b1, 1'b0, 4'h3, vc, 56'h0, tag};
  endfunction

  task automatic chk(string name, logic [70:0] act, logic [70:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, string tag);
    bus.pe_ready_send = v.rdy;
    bus.pe_flit       = v.flit;
    bus.credit_in     = v.cin;
    if (v.rdy && v.flit[70] && v.acc) exp_q.push_back(v.flit);
    @(posedge clk);
    #1;
    bus.pe_ready_send = 1'b0;
    bus.pe_flit       = NF;
    bus.credit_in     = 2'b00;
    chk({tag, " count"},    71'(bus.fifo_count), 71'(v.cnt));
    chk({tag, " overflow"}, 71'(bus.overflow),   71'(v.ovf));
    chk({tag, " cred_err"}, 71'(bus.credit_err), 71'(v.cerr));
    chk({tag, " emit"},     71'(bus.router_flit != NF), 71'(v.emit));
    if (bus.router_flit != NF) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL %s unexpected flit: got %h expected none", tag, bus.router_flit);
      end else begin
        chk({tag, " flit"}, bus.router_flit, exp_q.pop_front());
      end
    end
  endtask

  task automatic chk_credits(string tag, logic [2:0] c0, logic [2:0] c1);
    chk({tag, " credit0"}, 71'(dut.credit_q[0]), 71'(c0));
    chk({tag, " credit1"}, 71'(dut.credit_q[1]), 71'(c1));
  endtask

  initial begin
    logic [70:0] a_flit;
    logic [70:0] inv_flit;
    a_flit   = {1'b1, 1'b1, 4'b0111, 1'b0, 64'h5};
    inv_flit = mk(1'b1, 8'h77);
    inv_flit[70] = 1'b0;

    bus.pe_ready_send = 1'b0;
    bus.pe_flit       = NF;
    bus.credit_in     = 2'b00;
    rst_n             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset router", bus.router_flit, NF);
    chk("reset count",  71'(bus.fifo_count), 71'(3'd0));
    chk("reset ovf",    71'(bus.overflow), 71'(1'b0));
    chk("reset cerr",   71'(bus.credit_err), 71'(1'b0));
    chk_credits("reset", 3'd4, 3'd4);
    @(negedge clk);
    rst_n = 1'b1;

    // Single flit: shows up one cycle, two edges after the push.
    tbl.push_back(V(1'b1, a_flit, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF,     2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF,     2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    // Credit exhaustion on VC0 (restore to 4 first).
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd1 - 3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h11), 2'b00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h12), 2'b00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h13), 2'b00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h14), 2'b00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h15), 2'b00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b00, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
    // Head-of-line blocking: VC0 head starved, VC1 flit waits behind it.
    tbl.push_back(V(1'b1, mk(1'b0, 8'h21), 2'b00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b1, 8'h22), 2'b00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b00, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b00, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0));
    // Overflow with VC0 credit at 0; then pop and credit return share edges.
    tbl.push_back(V(1'b1, mk(1'b0, 8'h31), 2'b00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h32), 2'b00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h33), 2'b00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h34), 2'b00, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h35), 2'b00, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    // Strobe with valid bit clear is ignored.
    tbl.push_back(V(1'b1, inv_flit, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    // Full FIFO: push and pop on the same edge keeps count at 4.
    tbl.push_back(V(1'b1, mk(1'b0, 8'h41), 2'b00, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h42), 2'b00, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h43), 2'b00, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h44), 2'b00, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b1, mk(1'b0, 8'h45), 2'b00, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    // Credits back to full (VC0 1->4, VC1 3->4), then an excess return.
    tbl.push_back(V(1'b0, NF, 2'b11, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(V(1'b0, NF, 2'b01, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(V(1'b0, NF, 2'b10, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1));

    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end
    chk_credits("after table", 3'd4, 3'd4);

    // Reset mid-stream with three flits queued behind an empty VC0 counter.
    apply(V(1'b1, mk(1'b0, 8'h51), 2'b00, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1), "rst0");
    apply(V(1'b1, mk(1'b0, 8'h52), 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1), "rst1");
    apply(V(1'b1, mk(1'b0, 8'h53), 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1), "rst2");
    apply(V(1'b1, mk(1'b0, 8'h54), 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1), "rst3");
    apply(V(1'b1, mk(1'b0, 8'h55), 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1), "rst4");
    apply(V(1'b1, mk(1'b0, 8'h56), 2'b00, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1), "rst5");
    apply(V(1'b1, mk(1'b0, 8'h57), 2'b00, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1), "rst6");
    chk_credits("pre reset", 3'd0, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst router", bus.router_flit, NF);
    chk("async rst count",  71'(bus.fifo_count), 71'(3'd0));
    chk("async rst ovf",    71'(bus.overflow), 71'(1'b0));
    chk("async rst cerr",   71'(bus.credit_err), 71'(1'b0));
    chk_credits("async rst", 3'd4, 3'd4);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(V(1'b0, NF, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), $sformatf("post%0d", k));
    end
    apply(V(1'b1, mk(1'b1, 8'h61), 2'b00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0), "post_push");
    apply(V(1'b0, NF, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0), "post_pop");
    chk_credits("post", 3'd4, 3'd3);
    chk("scoreboard empty", 71'(exp_q.size()), 71'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pe_flit_injector.md
Name: pe_flit_injector

Overview:
- Network-side transmit interface for a processing element (PE) such as the XOR PE. It is the far end of the PE's output_flit/ready_send interface.
- Captures each 71-bit result flit the PE presents with ready_send and buffers it in a small in-order FIFO.
- Injects buffered flits into the local router input port under per-VC credit flow control.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CREDITS, 4, router input buffer slots per VC; also the reset value of each credit counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pe_flit  input  71  flit from the PE. [70] valid, [69] head/tail, [68:65] dest, [64] vc, [63:0] payload.
- pe_ready_send  input  1  PE strobe; one flit offered per cycle while high.
- router_flit  output  71  flit to the router; all-zero when not sending.
- credit_in  input  2  one-cycle credit return pulse per VC (bit i = VC i).
- fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a valid flit was dropped because the FIFO was full.
- credit_err  output  1  sticky flag: a credit was returned to a VC counter already at CREDITS.

Behaviour:
- Reset (async, rst_n=0): router_flit=0, fifo_count=0, overflow=0, credit_err=0, both credit counters=CREDITS, FIFO pointers=0.
- Accept rule: on a rising edge, if pe_ready_send=1 and pe_flit[70]=1, the flit is pushed.
  - Push succeeds if count<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the flit is dropped and overflow is set.
  - pe_ready_send=1 with pe_flit[70]=0 is ignored and has no flag.
- Each cycle pe_ready_send is high counts as a separate flit; consecutive-cycle strobes push consecutive flits.
- Pop rule: on each edge, if count>0 and the credit counter of the head flit's VC (head[64]) is >0, the head is popped.
  - On that same edge, router_flit is registered with the head flit unchanged.
  - That VC's credit counter is decremented.
  - On any edge with no pop, router_flit is registered to 0, so each injected flit appears for exactly one cycle.
- Latency: a flit pushed at edge N is the earliest candidate at edge N+1. With credit available and the FIFO empty, router_flit shows it in the cycle following edge N+1. There is no bypass path.
- Ordering is strict FIFO. A head blocked on VC x stalls all flits behind it, even those for VC y that has credit.
- Credit counters have width clog2(CREDITS)+1, one per VC.
  - credit_in[i] increments counter i.
  - A pop and a credit return on the same VC in the same edge leave the counter unchanged.
  - An increment that would exceed CREDITS is discarded and sets credit_err. The same-edge pop case is not an error.
- fifo_count changes by +1 (push only), -1 (pop only), or 0 (both or neither).
  - Full: push only when a same-edge pop occurs.
  - Empty: no pop; router_flit=0.
  - Pointers wrap modulo DEPTH.
- Sticky flags clear only on reset.
- Reset mid-operation discards FIFO contents and restores credits to CREDITS, regardless of flits in flight.
- A flit is forwarded unmodified, including dest, vc and the [69] bit. Dest is not checked.

Test Plan:
- Single flit: after reset, pulse pe_ready_send one cycle with pe_flit={1,1,4'b0111,0,64'h5} -> router_flit equals that flit for exactly one cycle, 2 edges after the push; VC0 credit=3; fifo_count back to 0.
- Credit exhaustion: push 5 flits on VC0 with no credit_in -> 4 injected on consecutive cycles, the 5th held (fifo_count=1). Then pulse credit_in=2'b01 -> the 5th injects on the next edge.
- Head-of-line blocking: drain VC0 credits, push a VC0 flit then a VC1 flit -> nothing injected until a VC0 credit returns, then VC0 then VC1 on consecutive cycles.
- Overflow: hold credits at 0, push 5 valid flits back to back -> fifo_count=4, overflow=1. After credit return, the first 4 flits emerge in order and the 5th never appears.
- Simultaneous events: full FIFO with push and pop on the same edge -> count stays 4 and the new flit is accepted. A credit_in for VC0 on the same edge as a VC0 pop -> counter unchanged, credit_err=0. A credit_in while the counter is at 4 -> credit_err=1.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with 3 flits queued -> router_flit=0 and fifo_count=0 immediately; credits=4; no queued flit emerges after release. Also: pe_ready_send=1 with pe_flit[70]=0 -> no push.
